// File: rtl/csa_resolve_pkg.sv
// csa_resolve shared types and sizing helpers.
// Optional zero flag: define CSA_RESOLVE_ZERO_FLAG_EN.
package csa_resolve_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_chunks(input int w, input int c);
    return w / c;
  endfunction

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/csa_resolve_seq_cpa_chunk.sv
// cpa_chunk: W-bit ripple adder built from full-adder cells.
// Carry-in at bit 0, carry-out from bit W-1.
module cpa_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_fa
    logic p;
    assign p      = a[i] ^ b[i];
    assign s[i]   = p ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & p);
  end

  assign co = c[W];

endmodule

// File: rtl/csa_resolve_seq.sv
// csa_resolve_seq: resolves a CSA (sum, carry) pair CHUNK bits/cycle.
// Optional zero flag: define CSA_RESOLVE_ZERO_FLAG_EN.
module csa_resolve_seq
  import csa_resolve_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s_in,
  input  logic [WIDTH-1:0] c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] result,
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
  output logic             out_zero,
`endif
  output logic             busy
);

  localparam int N  = num_chunks(WIDTH, CHUNK);
  localparam int KW = idx_w(N);

  state_t           state;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] c_q;
  logic             ctop;
  logic             cy;
  logic [KW-1:0]    k;

  logic [CHUNK-1:0] sa;
  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] r;
  logic             co;
  logic             last;

`ifdef CSA_RESOLVE_ZERO_FLAG_EN
  logic             zacc;
`endif

  // Select the operand chunk for the current index.
  always_comb begin
    sa   = s_q[k*CHUNK +: CHUNK];
    ca   = c_q[k*CHUNK +: CHUNK];
    last = (k == KW'(N - 1));
  end

  cpa_chunk #(
    .W (CHUNK)
  ) u_cpa (
    .a  (sa),
    .b  (ca),
    .ci (cy),
    .s  (r),
    .co (co)
  );

  // Control FSM, operand capture and chunked result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      s_q       <= '0;
      c_q       <= '0;
      ctop      <= 1'b0;
      cy        <= 1'b0;
      k         <= '0;
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
      zacc      <= 1'b0;
      out_zero  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            s_q      <= s_in;
            c_q      <= {c_in[WIDTH-2:0], 1'b0};
            ctop     <= c_in[WIDTH-1];
            cy       <= 1'b0;
            k        <= '0;
            result   <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= BUSY;
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
            zacc     <= 1'b1;
`endif
          end
        end
        BUSY: begin
          result[k*CHUNK +: CHUNK] <= r;
          cy <= co;
          k  <= k + 1'b1;
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
          zacc <= zacc & ~|r;
`endif
          if (last) begin
            result[WIDTH+1:WIDTH] <= {1'b0, ctop} + {1'b0, co};
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef CSA_RESOLVE_ZERO_FLAG_EN
            out_zero  <= zacc & ~|r & ~ctop & ~co;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
